// File: rtl/opensync_cf_update_ctrl_if.sv
// Byte-stream interface of opensync_cf_update_ctrl: receive side in, delayed stream plus metadata out.
// Counter signals exist only when OPENSYNC_CF_UPDATE_CTRL_CNT_EN is defined.
`timescale 1ns/1ps
interface opensync_cf_update_ctrl_if;
  logic [7:0]  iv_data;
  logic        i_data_wr;
  logic        i_tsn_or_tte;
  logic [63:0] iv_local_time;
  logic [7:0]  ov_data;
  logic        o_data_wr;
  logic [63:0] ov_receive_time;
  logic        o_cf_update_flag;
`ifdef OPENSYNC_CF_UPDATE_CTRL_CNT_EN
  logic [15:0] ov_update_cnt;
  logic [15:0] ov_frame_cnt;
`endif

  modport master (
    output iv_data, i_data_wr, i_tsn_or_tte, iv_local_time,
    input  ov_data, o_data_wr, ov_receive_time, o_cf_update_flag
`ifdef OPENSYNC_CF_UPDATE_CTRL_CNT_EN
    , input ov_update_cnt, ov_frame_cnt
`endif
  );

  modport slave (
    input  iv_data, i_data_wr, i_tsn_or_tte, iv_local_time,
    output ov_data, o_data_wr, ov_receive_time, o_cf_update_flag
`ifdef OPENSYNC_CF_UPDATE_CTRL_CNT_EN
    , output ov_update_cnt, ov_frame_cnt
`endif
  );
endinterface

// File: rtl/opensync_cf_update_ctrl.sv
// Per-frame correction-field update controller: timestamps byte 0, classifies the frame, delays data 2 cycles.
// Optional frame/update counters are enabled by defining OPENSYNC_CF_UPDATE_CTRL_CNT_EN.
`timescale 1ns/1ps
module opensync_cf_update_ctrl #(
  parameter logic [15:0] TSN_ETYPE = 16'h88F7,
  parameter logic [15:0] TTE_ETYPE = 16'h891D
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  opensync_cf_update_ctrl_if.slave    bus
);
  typedef enum logic [2:0] {SYNC, IDLE, HDR, UPD, PASS} state_t;

  state_t      r_state, w_next;
  logic [10:0] r_cnt, w_idx;
  logic [7:0]  r_et_hi, r_et_lo;
  logic        r_mode;
  logic [7:0]  r_d1, r_d2;
  logic        r_wr1, r_wr2;
  logic        r_flag;
  logic [63:0] r_rtime;
  logic        w_sof, w_x;

  assign w_sof = (r_state == IDLE) && bus.i_data_wr;
  assign w_idx = (r_state == IDLE) ? '0 : ((r_cnt == 11'h7FF) ? r_cnt : r_cnt + 11'd1);

  always_comb begin
    w_next = r_state;
    if (!bus.i_data_wr) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: w_next = HDR;
        HDR: begin
          if (!r_mode && w_idx == 11'd14)
            w_next = ({r_et_hi, r_et_lo} == TSN_ETYPE && bus.iv_data[3:0] <= 4'h3) ? UPD : PASS;
          else if (r_mode && w_idx == 11'd13)
            w_next = ({r_et_hi, bus.iv_data} == TTE_ETYPE) ? UPD : PASS;
        end
        default: ;
      endcase
    end
  end

  // The flag tracks the byte one stage ahead of the output; r_state==UPD covers the
  // gap cycle so the old frame's last output byte stays flagged while the FSM restarts.
  assign w_x = (w_next == UPD) || (r_state == UPD);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= SYNC;
      r_cnt   <= '0;
      r_et_hi <= '0;
      r_et_lo <= '0;
      r_mode  <= 1'b0;
      r_rtime <= '0;
    end else begin
      r_state <= w_next;
      if (bus.i_data_wr) r_cnt <= w_idx;
      if (w_sof) begin
        r_mode  <= bus.i_tsn_or_tte;
        r_rtime <= bus.iv_local_time;
      end
      if (r_state == HDR && w_idx == 11'd12) r_et_hi <= bus.iv_data;
      if (r_state == HDR && w_idx == 11'd13) r_et_lo <= bus.iv_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_d1   <= '0;
      r_d2   <= '0;
      r_wr1  <= 1'b0;
      r_wr2  <= 1'b0;
      r_flag <= 1'b0;
    end else begin
      r_d1   <= bus.iv_data;
      r_wr1  <= bus.i_data_wr;
      r_d2   <= r_d1;
      r_wr2  <= r_wr1;
      r_flag <= r_wr1 && w_x;
    end
  end

  assign bus.ov_data          = r_d2;
  assign bus.o_data_wr        = r_wr2;
  assign bus.o_cf_update_flag = r_flag;
  assign bus.ov_receive_time  = r_rtime;

`ifdef OPENSYNC_CF_UPDATE_CTRL_CNT_EN
  logic [15:0] r_frame_cnt, r_update_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame_cnt  <= '0;
      r_update_cnt <= '0;
    end else begin
      if (w_sof) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_next == UPD && r_state != UPD) r_update_cnt <= r_update_cnt + 16'd1;
    end
  end

  assign bus.ov_frame_cnt  = r_frame_cnt;
  assign bus.ov_update_cnt = r_update_cnt;
`endif
endmodule

// File: tb/tb_opensync_cf_update_ctrl.sv
// Scoreboard bench for opensync_cf_update_ctrl: driver pushes expected output bytes, monitor pops and compares.
// Counter checks are included when OPENSYNC_CF_UPDATE_CTRL_CNT_EN is defined.
`timescale 1ns/1ps
module tb_opensync_cf_update_ctrl;
  localparam logic [15:0] TSN = 16'h88F7;
  localparam logic [15:0] TTE = 16'h891D;

  typedef struct {
    logic [7:0]  d;
    logic        f;
    logic [63:0] t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   m_frames = 0;
  int   m_updates = 0;
  exp_t sb[$];

  always #4 clk = ~clk;

  opensync_cf_update_ctrl_if bus ();

  opensync_cf_update_ctrl #(.TSN_ETYPE(TSN), .TTE_ETYPE(TTE)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A frame is flagged when its decision byte exists and the header matches the mode's rule.
  function automatic bit model_flag(input int len, input bit mode, input logic [15:0] et,
                                    input logic [7:0] b14);
    if (mode) return (len > 13) && (et == TTE);
    return (len > 14) && (et == TSN) && (b14[3:0] <= 4'h3);
  endfunction

  task automatic idle_cycle();
    @(posedge clk); #1;
    bus.i_data_wr     = 1'b0;
    bus.iv_data       = 8'($urandom);
    bus.i_tsn_or_tte  = 1'($urandom);
    bus.iv_local_time = bus.iv_local_time + 64'd1;
  endtask

  // rst_at >= 0 asserts reset while byte rst_at is driven and releases it at byte rst_at+5.
  task automatic send_frame(input int len, input bit mode, input logic [15:0] et,
                            input logic [7:0] b14, input int gap, input logic [63:0] t0,
                            input int rst_at);
    bit          fl;
    bit          after_rst;
    int          thr;
    logic [7:0]  d;
    logic [63:0] rt;
    fl = model_flag(len, mode, et, b14);
    thr = mode ? 12 : 13;
    after_rst = 1'b0;
    rt = '0;
    m_frames++;
    if (fl) m_updates++;
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        after_rst = 1'b1;
        m_frames = 0;
        m_updates = 0;
        chk("rst_mid_data", 64'(bus.ov_data), 64'h0);
        chk("rst_mid_wr", 64'(bus.o_data_wr), 64'h0);
        chk("rst_mid_flag", 64'(bus.o_cf_update_flag), 64'h0);
        chk("rst_mid_rtime", bus.ov_receive_time, 64'h0);
      end
      if (rst_at >= 0 && k == rst_at + 5) rst = 1'b0;
      d = 8'($urandom);
      if (k == 12) d = et[15:8];
      if (k == 13) d = et[7:0];
      if (k == 14) d = b14;
      bus.iv_data      = d;
      bus.i_data_wr    = 1'b1;
      bus.i_tsn_or_tte = (k == 0) ? mode : 1'($urandom);
      if (k == 0 && t0 != 64'h0) bus.iv_local_time = t0;
      else bus.iv_local_time = bus.iv_local_time + 64'd1;
      if (k == 0) rt = bus.iv_local_time;
      if (!(rst_at >= 0 && k >= rst_at - 2 && k < rst_at + 5))
        sb.push_back('{d, (fl && k >= thr && !after_rst), (after_rst ? 64'h0 : rt)});
    end
    for (int g = 0; g < gap; g++) idle_cycle();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.o_data_wr) begin
        if (sb.size() == 0) begin
          chk("extra_byte", 64'(bus.ov_data), 64'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("data", 64'(bus.ov_data), 64'(e.d));
          chk("flag", 64'(bus.o_cf_update_flag), 64'(e.f));
          chk("rtime", bus.ov_receive_time, e.t);
        end
      end else begin
        chk("flag_idle", 64'(bus.o_cf_update_flag), 64'h0);
      end
    end
  end

  initial begin
    bus.iv_data       = '0;
    bus.i_data_wr     = 1'b0;
    bus.i_tsn_or_tte  = 1'b0;
    bus.iv_local_time = 64'h500;
    repeat (3) idle_cycle();
    chk("reset_data", 64'(bus.ov_data), 64'h0);
    chk("reset_wr", 64'(bus.o_data_wr), 64'h0);
    chk("reset_flag", 64'(bus.o_cf_update_flag), 64'h0);
    chk("reset_rtime", bus.ov_receive_time, 64'h0);
`ifdef OPENSYNC_CF_UPDATE_CTRL_CNT_EN
    chk("reset_fcnt", 64'(bus.ov_frame_cnt), 64'h0);
    chk("reset_ucnt", 64'(bus.ov_update_cnt), 64'h0);
`endif
    rst = 1'b0;
    repeat (2) idle_cycle();

    send_frame(64, 1'b0, TSN, 8'h10, 2, 64'h1000, -1);
    send_frame(64, 1'b0, TSN, 8'h0B, 2, 64'h1100, -1);
    send_frame(64, 1'b1, TTE, 8'h55, 2, 64'h1200, -1);
    send_frame(64, 1'b0, TTE, 8'h00, 2, 64'h1300, -1);
    send_frame(10, 1'b0, TSN, 8'h10, 1, 64'h1800, -1);
    send_frame(64, 1'b0, TSN, 8'h10, 1, 64'h2000, -1);
    send_frame(64, 1'b1, TSN, 8'h10, 1, 64'h2100, -1);
    send_frame(64, 1'b0, TSN, 8'h03, 2, 64'h3000, 20);
    send_frame(64, 1'b0, TSN, 8'h01, 2, 64'h4000, -1);
    send_frame(14, 1'b0, TSN, 8'h00, 1, 64'h0, -1);
    send_frame(13, 1'b1, TTE, 8'h00, 1, 64'h0, -1);
    send_frame(15, 1'b0, TSN, 8'h02, 1, 64'h0, -1);
    send_frame(14, 1'b1, TTE, 8'h00, 1, 64'h0, -1);

    for (int n = 0; n < 40; n++) begin
      logic [15:0] et;
      case ($urandom % 3)
        0: et = TSN;
        1: et = TTE;
        default: et = 16'($urandom);
      endcase
      send_frame(int'($urandom_range(1, 80)), 1'($urandom), et, 8'($urandom),
                 int'($urandom_range(1, 3)), 64'h0, -1);
    end

    repeat (6) idle_cycle();
    chk("sb_empty", 64'(sb.size()), 64'h0);
`ifdef OPENSYNC_CF_UPDATE_CTRL_CNT_EN
    chk("frame_cnt", 64'(bus.ov_frame_cnt), 64'(16'(m_frames)));
    chk("update_cnt", 64'(bus.ov_update_cnt), 64'(16'(m_updates)));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
